// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and word geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prog_loader_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Bytes assembled into one 32-bit instruction word
    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/prog_loader_if.sv
// Bundle of loader control, byte stream, instruction-memory write and fetch-stage controls.
// Latency: n/a (wiring only).
// Backpressure: byte stream uses valid/ready; a byte moves when byte_valid and byte_ready are both high.
// master: drives start/len/byte stream, observes everything else.
// slave : the loader; drives byte_ready, memory write port, core controls and status.
interface prog_loader_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic [ADDR_W:0]   len;
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_stall;
    logic              core_pc_sel;
    logic [31:0]       core_jmp_addr;
    logic              core_flush;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, len, byte_data, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata,
        input  core_stall, core_pc_sel, core_jmp_addr, core_flush,
        input  busy, done, err
    );

    modport slave (
        input  start, len, byte_data, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata,
        output core_stall, core_pc_sel, core_jmp_addr, core_flush,
        output busy, done, err
    );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; owns the byte counter.
// Latency: o_word_vld/o_word_dat are combinational in the cycle the last byte of a word is accepted.
// Backpressure: none of its own; i_byte_vld must already be the qualified transfer (valid & ready).
// Ports: i_clk, i_rst (sync, active-high), i_clr (restart at byte 0), i_byte_vld/i_byte_dat in,
//        o_word_vld/o_word_dat out.
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte_dat,
    output logic        o_word_vld,
    output logic [31:0] o_word_dat
);
    localparam int                ASM_W   = 8 * (BYTES_PER_WORD - 1);
    localparam logic [BCNT_W-1:0] LP_LAST = BCNT_W'(BYTES_PER_WORD - 1);

    logic [BCNT_W-1:0] r_byte_cnt;
    logic [ASM_W-1:0]  r_asm;      // holds the first three bytes of the current word

    // The final byte is spliced in directly so the word is ready in its accept cycle.
    assign o_word_vld = i_byte_vld && (r_byte_cnt == LP_LAST);
    assign o_word_dat = {i_byte_dat, r_asm};

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_byte_cnt <= '0;
            r_asm      <= '0;
        end else if (i_byte_vld) begin
            r_byte_cnt <= r_byte_cnt + BCNT_W'(1);   // wraps 3 -> 0
            for (int i = 0; i < BYTES_PER_WORD - 1; i++) begin
                if (r_byte_cnt == BCNT_W'(i)) begin
                    r_asm[i*8 +: 8] <= i_byte_dat;
                end
            end
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Streams a program byte-wise into instruction memory while stalling the core, then restarts fetch at 0.
// Latency: word write one cycle after its 4th byte; RELEASE two cycles after the last byte; done one after that.
// Backpressure: byte_ready high throughout LOAD, dropped with the final write; never times out on idle input.
// Ports: i_clk, i_rst (sync, active-high), io_ldr (prog_loader_if.slave).
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ROM_SIZE = 512,
    parameter int ADDR_W   = 9
) (
    input  logic         i_clk,
    input  logic         i_rst,
    prog_loader_if.slave io_ldr
);
    localparam logic [ADDR_W:0] LP_ROM  = (ADDR_W + 1)'(ROM_SIZE);
    localparam logic [ADDR_W:0] LP_ONE  = (ADDR_W + 1)'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_last;       // index of the final word (len-1)
    logic [ADDR_W-1:0] r_word_cnt;
    logic              r_byte_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_stall;
    logic              r_pc_sel;
    logic              r_flush;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_xfer;
    logic              w_len_ok;
    logic [ADDR_W-1:0] w_len_m1;
    logic              w_clr;
    logic              w_word_vld;
    logic [31:0]       w_word_dat;

    assign w_xfer   = io_ldr.byte_valid && r_byte_ready;
    assign w_len_ok = (io_ldr.len != '0) && (io_ldr.len <= LP_ROM);
    // len <= ROM_SIZE, so len-1 always fits in an address
    assign w_len_m1 = ADDR_W'(io_ldr.len - LP_ONE);
    assign w_clr    = (r_state == ST_IDLE) && io_ldr.start && w_len_ok;

    byte_packer u_packer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_clr),
        .i_byte_vld (w_xfer),
        .i_byte_dat (io_ldr.byte_data),
        .o_word_vld (w_word_vld),
        .o_word_dat (w_word_dat)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_last       <= '0;
            r_word_cnt   <= '0;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_stall      <= 1'b0;
            r_pc_sel     <= 1'b0;
            r_flush      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (io_ldr.start) begin
                        if (w_len_ok) begin
                            r_state      <= ST_LOAD;
                            r_last       <= w_len_m1;
                            r_word_cnt   <= '0;
                            r_byte_ready <= 1'b1;
                            r_stall      <= 1'b1;
                            r_busy       <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_word_vld) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_word_cnt;
                        r_mem_wdata <= w_word_dat;
                        // Final word: stop taking bytes; the counter is left at len-1 so it cannot wrap.
                        if (r_word_cnt == r_last) begin
                            r_byte_ready <= 1'b0;
                        end else begin
                            r_word_cnt <= r_word_cnt + ADDR_W'(1);
                        end
                    end
                    // byte_ready low inside LOAD only happens in the final-write cycle.
                    if (!r_byte_ready) begin
                        r_state  <= ST_RELEASE;
                        r_stall  <= 1'b0;
                        r_pc_sel <= 1'b1;
                        r_flush  <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    r_state  <= ST_IDLE;
                    r_pc_sel <= 1'b0;
                    r_flush  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_ldr.byte_ready    = r_byte_ready;
    assign io_ldr.mem_we        = r_mem_we;
    assign io_ldr.mem_addr      = r_mem_addr;
    assign io_ldr.mem_wdata     = r_mem_wdata;
    assign io_ldr.core_stall    = r_stall;
    assign io_ldr.core_pc_sel   = r_pc_sel;
    assign io_ldr.core_jmp_addr = 32'h0;     // fetch always restarts at address 0
    assign io_ldr.core_flush    = r_flush;
    assign io_ldr.busy          = r_busy;
    assign io_ldr.done          = r_done;
    assign io_ldr.err           = r_err;
endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: start-acceptance vectors, directed loads, abort, random loads, full-depth load.
// Latency: n/a.
// Backpressure: byte_valid driven with random or patterned gaps.
module tb_prog_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(9)) ldr ();

    prog_loader #(.ROM_SIZE(512), .ADDR_W(9)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_ldr (ldr)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int hold_bad = 0;
    int last_we_cyc = -1;
    logic [8:0]  last_a = '0;
    logic [31:0] last_d = '0;
    logic [8:0]  wr_a_q[$];
    logic [31:0] wr_d_q[$];
    logic [7:0]  prog_q[$];

    typedef struct {
        bit rst_in;
        int len;
        bit e_err;
        bit e_busy;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle and record what the DUT shows #1 after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ldr.mem_we === 1'b1) begin
            wr_a_q.push_back(ldr.mem_addr);
            wr_d_q.push_back(ldr.mem_wdata);
            last_a = ldr.mem_addr;
            last_d = ldr.mem_wdata;
            last_we_cyc = cyc;
        end else if (ldr.mem_addr !== last_a || ldr.mem_wdata !== last_d) begin
            hold_bad++;
        end
        if (ldr.done === 1'b1) done_cnt++;
        if (ldr.err === 1'b1) err_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        last_a = '0;
        last_d = '0;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [127:0] outs();
        return 128'({ldr.byte_ready, ldr.mem_we, ldr.mem_addr, ldr.mem_wdata, ldr.core_stall,
                     ldr.core_pc_sel, ldr.core_jmp_addr, ldr.core_flush, ldr.busy, ldr.done, ldr.err});
    endfunction

    function automatic logic [31:0] model_word(input int j);
        return 32'(prog_q[4*j]) + 32'(prog_q[4*j+1]) * 256 +
               32'(prog_q[4*j+2]) * 65536 + 32'(prog_q[4*j+3]) * 16777216;
    endfunction

    task automatic fill_prog(input int n);
        prog_q.delete();
        for (int i = 0; i < n; i++) prog_q.push_back(8'($urandom));
    endtask

    // Load n words from prog_q (extra bytes in prog_q are offered but must be refused).
    task automatic run_load(input string tag, input int n, input int gap_pct, input bit alt, input bit stray);
        int idx = 0, last_acc = -100, rel_cyc = -1, done_cyc = -1, rel_n = 0, rel_bad = 0;
        int stall_bad = 0, err0, mism = 0, budget;
        bit fin = 1'b0;
        bit vld;
        budget = 20 * n + 50;
        wr_a_q.delete();
        wr_d_q.delete();
        err0 = err_cnt;
        ldr.start = 1'b1;
        ldr.len = 10'(n);
        tick();
        ldr.start = 1'b0;
        for (int k = 0; k < budget && !fin; k++) begin
            if (ldr.core_pc_sel) begin
                rel_n++;
                rel_cyc = cyc;
                if (!(ldr.core_flush && !ldr.core_stall && ldr.core_jmp_addr == 32'h0 && !ldr.byte_ready))
                    rel_bad++;
            end
            if (ldr.done) begin
                done_cyc = cyc;
                fin = 1'b1;
            end
            if (rel_cyc < 0 && !fin && (!ldr.core_stall || !ldr.busy)) stall_bad++;
            if (!fin) begin
                vld = (idx < prog_q.size()) && (alt ? (k % 2 == 0) : (int'($urandom_range(99)) >= gap_pct));
                ldr.byte_valid = vld;
                ldr.byte_data = vld ? prog_q[idx] : 8'($urandom);
                ldr.start = stray && ($urandom_range(9) == 0);
                ldr.len = 10'($urandom);
                if (vld && ldr.byte_ready) begin
                    idx++;
                    last_acc = cyc;
                end
                tick();
            end
        end
        ldr.byte_valid = 1'b0;
        ldr.start = 1'b0;
        for (int j = 0; j < wr_a_q.size() && j < n; j++)
            if (wr_a_q[j] != 9'(j) || wr_d_q[j] != model_word(j)) mism++;
        check({tag, " finished"}, fin, 1);
        check({tag, " bytes accepted"}, idx, 4 * n);
        check({tag, " write count"}, wr_a_q.size(), n);
        check({tag, " word mismatches"}, mism, 0);
        check({tag, " last write cycle"}, last_we_cyc - last_acc, 1);
        check({tag, " release cycle"}, rel_cyc - last_acc, 2);
        check({tag, " release count"}, rel_n, 1);
        check({tag, " release outputs bad"}, rel_bad, 0);
        check({tag, " done cycle"}, done_cyc - last_acc, 3);
        check({tag, " stall gaps"}, stall_bad, 0);
        check({tag, " spurious err"}, err_cnt - err0, 0);
        check({tag, " idle outputs"},
              {ldr.busy, ldr.core_stall, ldr.core_pc_sel, ldr.core_flush, ldr.byte_ready, ldr.mem_we}, 0);
        tick();
        check({tag, " done one cycle"}, ldr.done, 0);
    endtask

    initial begin
        int acc, w0, done0;
        ldr.start = 1'b0;
        ldr.len = '0;
        ldr.byte_data = '0;
        ldr.byte_valid = 1'b0;
        vecs[0] = '{1'b0, 0,    1'b1, 1'b0};
        vecs[1] = '{1'b0, 513,  1'b1, 1'b0};
        vecs[2] = '{1'b0, 1023, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 5,    1'b0, 1'b0};
        vecs[4] = '{1'b0, 1,    1'b0, 1'b1};
        vecs[5] = '{1'b0, 512,  1'b0, 1'b1};

        do_reset();
        do_reset();
        check("reset outputs", outs(), 0);

        // Start acceptance / rejection table
        for (int i = 0; i < 6; i++) begin
            w0 = wr_a_q.size();
            ldr.start = 1'b1;
            ldr.len = 10'(vecs[i].len);
            rst = vecs[i].rst_in;
            if (vecs[i].rst_in) begin
                last_a = '0;
                last_d = '0;
            end
            tick();
            ldr.start = 1'b0;
            rst = 1'b0;
            check($sformatf("vec%0d err", i), ldr.err, vecs[i].e_err);
            check($sformatf("vec%0d busy", i), ldr.busy, vecs[i].e_busy);
            check($sformatf("vec%0d stall", i), ldr.core_stall, vecs[i].e_busy);
            check($sformatf("vec%0d byte_ready", i), ldr.byte_ready, vecs[i].e_busy);
            tick();
            check($sformatf("vec%0d err one cycle", i), ldr.err, 0);
            check($sformatf("vec%0d no writes", i), wr_a_q.size() - w0, 0);
            if (vecs[i].e_busy) do_reset();
        end

        // Two-word program, bytes back-to-back
        prog_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load("two words", 2, 0, 1'b0, 1'b0);
        if (wr_d_q.size() == 2) begin
            check("two words data0", wr_d_q[0], 32'h00000013);
            check("two words data1", wr_d_q[1], 32'h00100093);
        end else begin
            check("two words size", wr_d_q.size(), 2);
        end

        // One word, byte_valid every other cycle
        fill_prog(7);
        run_load("alternating", 1, 0, 1'b1, 1'b0);

        // Reset after six bytes of a three-word load, with a seventh byte offered alongside
        fill_prog(12);
        wr_a_q.delete();
        wr_d_q.delete();
        done0 = done_cnt;
        ldr.start = 1'b1;
        ldr.len = 10'd3;
        tick();
        ldr.start = 1'b0;
        acc = 0;
        for (int k = 0; k < 40 && acc < 6; k++) begin
            ldr.byte_valid = 1'b1;
            ldr.byte_data = prog_q[acc];
            if (ldr.byte_ready) acc++;
            tick();
        end
        check("abort bytes before reset", acc, 6);
        ldr.byte_valid = 1'b1;
        ldr.byte_data = prog_q[6];
        do_reset();
        ldr.byte_valid = 1'b0;
        check("abort outputs", outs(), 0);
        repeat (6) tick();
        check("abort write count", wr_a_q.size(), 1);
        if (wr_a_q.size() > 0) check("abort write addr0", {wr_a_q[0], wr_d_q[0]}, {9'd0, model_word(0)});
        check("abort no done", done_cnt - done0, 0);
        check("abort stays idle", {ldr.busy, ldr.core_stall, ldr.byte_ready}, 0);
        fill_prog(4);
        run_load("reload", 1, 0, 1'b0, 1'b0);

        // Random programs, random gaps, stray start pulses during the load
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 12));
            fill_prog(4 * n + int'($urandom_range(0, 6)));
            run_load($sformatf("rand%0d", r), n, int'($urandom_range(0, 60)), 1'b0, 1'b1);
        end

        // Full-depth load with five trailing bytes
        fill_prog(4 * 512 + 5);
        run_load("full", 512, 0, 1'b0, 1'b0);
        if (wr_a_q.size() > 0) check("full last addr", wr_a_q[wr_a_q.size()-1], 9'd511);

        check("addr/data hold violations", hold_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
